// File: rtl/computation_control_pkg.sv
// Shared types and widths for the computation-control sequencer.
// Holds the FSM state set and the per-array control word.
package computation_control_pkg;

  localparam int MAX_KERNEL_STEPS = 4;
  localparam int BANK_DEPTH       = 8;
  localparam int MAX_COLUMNS      = 256;

  localparam int KSW = $clog2(MAX_KERNEL_STEPS);
  localparam int AW  = $clog2(BANK_DEPTH);
  localparam int CW  = $clog2(MAX_COLUMNS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_DRAIN   = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [KSW-1:0] kernel_step_index;
    logic [AW-1:0]  weight_memory_address;
    logic           reset_accumulators;
    logic           shift_partial_result;
    logic [KSW-1:0] shift_output_steps_counter;
    logic           column_is_last;
  } control_word_t;

endpackage

// File: rtl/computation_control_if.sv
// Scheduler-side request/config plus per-array control fan-out.
// The sequencer owns the master modport.
interface computation_control_if
  import computation_control_pkg::*;
#(
  parameter int NUMBER_OF_PE_ARRAYS_PER_ROW = 32
);

  localparam int N = NUMBER_OF_PE_ARRAYS_PER_ROW;

  logic           start;
  logic [KSW-1:0] cfg_kernel_steps_minus_one;
  logic [CW-1:0]  cfg_columns_minus_one;
  logic [AW-1:0]  cfg_weight_base_address;

  logic [KSW-1:0] kernel_step_index [N];
  logic [AW-1:0]  weight_memory_address [N];
  logic           reset_accumulators [N];
  logic           shift_partial_result [N];
  logic [KSW-1:0] shift_output_steps_counter [N];

  logic shift_output_steps_counter_finished_flag;
  logic last_column_finished;
  logic delayed_shift_partial_result_flag;
  logic busy;
  logic done;

  modport master (
    input  start,
    input  cfg_kernel_steps_minus_one,
    input  cfg_columns_minus_one,
    input  cfg_weight_base_address,
    output kernel_step_index,
    output weight_memory_address,
    output reset_accumulators,
    output shift_partial_result,
    output shift_output_steps_counter,
    output shift_output_steps_counter_finished_flag,
    output last_column_finished,
    output delayed_shift_partial_result_flag,
    output busy,
    output done
  );

  modport slave (
    output start,
    output cfg_kernel_steps_minus_one,
    output cfg_columns_minus_one,
    output cfg_weight_base_address,
    input  kernel_step_index,
    input  weight_memory_address,
    input  reset_accumulators,
    input  shift_partial_result,
    input  shift_output_steps_counter,
    input  shift_output_steps_counter_finished_flag,
    input  last_column_finished,
    input  delayed_shift_partial_result_flag,
    input  busy,
    input  done
  );

endinterface

// File: rtl/computation_control_sequencer_skew.sv
// Systolic skew chain: stage i carries the array-0 control word
// delayed by i cycles; clears synchronously on resetn low.
module control_skew_pipeline
  import computation_control_pkg::*;
#(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  control_word_t word_in,
  output control_word_t word_out [N]
);

  for (genvar i = 0; i < N; i++) begin : g_stage
    if (i == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (!resetn) word_out[i] <= '0;
        else         word_out[i] <= word_in;
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (!resetn) word_out[i] <= '0;
        else         word_out[i] <= word_out[i-1];
      end
    end
  end

endmodule

// File: rtl/computation_control_sequencer.sv
// Per-column kernel/shift sequencer for a row of PE arrays.
// The array-0 word is built from next-state so it lands registered.
module computation_control_sequencer
  import computation_control_pkg::*;
#(
  parameter int NUMBER_OF_PE_ARRAYS_PER_ROW          = 32,
  parameter int SUPPORTED_MAX_NUMBER_OF_KERNEL_STEPS = 4,
  parameter int WEIGHT_BANK_DEPTH                    = 8,
  parameter int SUPPORTED_MAX_NUMBER_OF_COLUMNS      = 256
) (
  input logic                  clk,
  input logic                  resetn,
  computation_control_if.master ctl
);

  localparam int N = NUMBER_OF_PE_ARRAYS_PER_ROW;
  localparam int KERNEL_STEPS_COUNTER_BIT_WIDTH =
    $clog2(SUPPORTED_MAX_NUMBER_OF_KERNEL_STEPS);
  localparam int KW  = KERNEL_STEPS_COUNTER_BIT_WIDTH;
  localparam int AWL = $clog2(WEIGHT_BANK_DEPTH);
  localparam int CWL = $clog2(SUPPORTED_MAX_NUMBER_OF_COLUMNS);
  localparam int DCW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] COMPUTE = ST_COMPUTE;
  localparam logic [1:0] SHIFT   = ST_SHIFT;
  localparam logic [1:0] DRAIN   = ST_DRAIN;

  logic [1:0]     state_q, state_d;
  logic [KW-1:0]  step_q, step_d;
  logic [CWL-1:0] col_q, col_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic [KW-1:0]  k_q, k_d;
  logic [CWL-1:0] c_q, c_d;
  logic [AWL-1:0] base_q, base_d;
  logic           done_q, done_d;
  logic           dly_q;

  control_word_t  word_d;
  control_word_t  word [N];

  // One step counter serves both the kernel and shift phases.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    col_d   = col_q;
    drain_d = drain_q;
    k_d     = k_q;
    c_d     = c_q;
    base_d  = base_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctl.start) begin
          state_d = COMPUTE;
          step_d  = '0;
          col_d   = '0;
          k_d     = ctl.cfg_kernel_steps_minus_one;
          c_d     = ctl.cfg_columns_minus_one;
          base_d  = ctl.cfg_weight_base_address;
        end
      end
      COMPUTE: begin
        if (step_q == k_q) begin
          state_d = SHIFT;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      SHIFT: begin
        if (step_q == k_q) begin
          step_d = '0;
          if (col_q != c_q) begin
            col_d   = col_q + 1'b1;
            state_d = COMPUTE;
          end else if (N == 1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DCW'(N - 2)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word_d = '0;
    if (state_d == COMPUTE) begin
      word_d.kernel_step_index     = step_d;
      word_d.weight_memory_address = base_d + AWL'(step_d);
      word_d.reset_accumulators    = (step_d == '0);
      word_d.column_is_last        = (col_d == c_d);
    end else if (state_d == SHIFT) begin
      word_d.shift_partial_result       = 1'b1;
      word_d.shift_output_steps_counter = step_d;
      word_d.column_is_last             = (col_d == c_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      step_q  <= '0;
      col_q   <= '0;
      drain_q <= '0;
      k_q     <= '0;
      c_q     <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      col_q   <= col_d;
      drain_q <= drain_d;
      k_q     <= k_d;
      c_q     <= c_d;
      base_q  <= base_d;
      done_q  <= done_d;
      dly_q   <= word[0].shift_partial_result;
    end
  end

  control_skew_pipeline #(
    .N(N)
  ) u_skew (
    .clk     (clk),
    .resetn  (resetn),
    .word_in (word_d),
    .word_out(word)
  );

  for (genvar i = 0; i < N; i++) begin : g_fan
    assign ctl.kernel_step_index[i]          = word[i].kernel_step_index;
    assign ctl.weight_memory_address[i]      = word[i].weight_memory_address;
    assign ctl.reset_accumulators[i]         = word[i].reset_accumulators;
    assign ctl.shift_partial_result[i]       = word[i].shift_partial_result;
    assign ctl.shift_output_steps_counter[i] =
      word[i].shift_output_steps_counter;
  end

  assign ctl.shift_output_steps_counter_finished_flag =
    word[N-1].shift_partial_result &&
    (word[N-1].shift_output_steps_counter == k_q);
  assign ctl.last_column_finished =
    ctl.shift_output_steps_counter_finished_flag &&
    word[N-1].column_is_last;
  assign ctl.delayed_shift_partial_result_flag = dly_q;
  assign ctl.busy = (state_q != IDLE);
  assign ctl.done = done_q;

endmodule

// File: tb/tb_computation_control_sequencer.sv
// Bench for the computation-control sequencer: N=4 and N=1 instances,
// checked against a column/phase timing model and literal expectations.
module tb_computation_control_sequencer;

  localparam int NA = 4;
  localparam int NB = 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  computation_control_if #(.NUMBER_OF_PE_ARRAYS_PER_ROW(NA)) if_a ();
  computation_control_if #(.NUMBER_OF_PE_ARRAYS_PER_ROW(NB)) if_b ();

  computation_control_sequencer #(
    .NUMBER_OF_PE_ARRAYS_PER_ROW(NA)
  ) dut_a (
    .clk   (clk),
    .resetn(resetn),
    .ctl   (if_a)
  );

  computation_control_sequencer #(
    .NUMBER_OF_PE_ARRAYS_PER_ROW(NB)
  ) dut_b (
    .clk   (clk),
    .resetn(resetn),
    .ctl   (if_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  bit m_active = 1'b0;
  int m_s = 0;
  int m_k = 1;
  int m_c = 1;
  int m_b = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d",
               name, cyc, act, exp);
    end
  endtask

  // Array-0 control for relative cycle u of a job (start at u=0).
  function automatic void model_word(
    input int u, input int k, input int c, input int b,
    output int ksi, output int addr, output int rst,
    output int sh, output int scnt, output int last);
    int p, r;
    ksi = 0; addr = 0; rst = 0; sh = 0; scnt = 0; last = 0;
    if (u >= 1 && u <= 2 * k * c) begin
      p = u - 1;
      r = p % (2 * k);
      last = ((p / (2 * k)) == c - 1) ? 1 : 0;
      if (r < k) begin
        ksi = r;
        addr = (b + r) % 8;
        rst = (r == 0) ? 1 : 0;
      end else begin
        sh = 1;
        scnt = r - k;
      end
    end
  endfunction

  function automatic bit m_busy_at(input int c);
    int u;
    u = c - m_s;
    return m_active && u >= 1 && u <= 2 * m_k * m_c + NA - 1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!resetn) begin
      m_active <= 1'b0;
    end else if (if_a.start && !m_busy_at(cyc)) begin
      m_active <= 1'b1;
      m_s <= cyc;
      m_k <= int'(if_a.cfg_kernel_steps_minus_one) + 1;
      m_c <= int'(if_a.cfg_columns_minus_one) + 1;
      m_b <= int'(if_a.cfg_weight_base_address);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int u, ksi, addr, rst, sh, scnt, last, fin;
      u = m_active ? (cyc - m_s) : -1000;
      for (int i = 0; i < NA; i++) begin
        model_word(u - i, m_k, m_c, m_b, ksi, addr, rst, sh, scnt, last);
        chk($sformatf("ksi[%0d]", i), 32'(if_a.kernel_step_index[i]), ksi);
        chk($sformatf("addr[%0d]", i),
            32'(if_a.weight_memory_address[i]), addr);
        chk($sformatf("rst[%0d]", i), 32'(if_a.reset_accumulators[i]), rst);
        chk($sformatf("shift[%0d]", i),
            32'(if_a.shift_partial_result[i]), sh);
        chk($sformatf("scnt[%0d]", i),
            32'(if_a.shift_output_steps_counter[i]), scnt);
        if (i == NA - 1) begin
          fin = (sh == 1 && scnt == m_k - 1) ? 1 : 0;
          chk("fin_flag",
              32'(if_a.shift_output_steps_counter_finished_flag), fin);
          chk("last_col", 32'(if_a.last_column_finished),
              (fin == 1 && last == 1) ? 1 : 0);
        end
      end
      model_word(u - 1, m_k, m_c, m_b, ksi, addr, rst, sh, scnt, last);
      chk("dly_shift", 32'(if_a.delayed_shift_partial_result_flag), sh);
      chk("busy", 32'(if_a.busy), m_busy_at(cyc) ? 1 : 0);
      chk("done", 32'(if_a.done),
          (m_active && u == 2 * m_k * m_c + NA) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit s, input int k1, input int c1,
                         input int b);
    if_a.start = s;
    if_a.cfg_kernel_steps_minus_one = 2'(k1);
    if_a.cfg_columns_minus_one = 8'(c1);
    if_a.cfg_weight_base_address = 3'(b);
  endtask

  initial begin
    drive_a(1'b0, 0, 0, 0);
    if_b.start = 1'b0;
    if_b.cfg_kernel_steps_minus_one = '0;
    if_b.cfg_columns_minus_one = '0;
    if_b.cfg_weight_base_address = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_busy_a", 32'(if_a.busy), 0);
    chk("rst_done_a", 32'(if_a.done), 0);
    chk("rst_busy_b", 32'(if_b.busy), 0);
    chk("rst_shift3", 32'(if_a.shift_partial_result[3]), 0);
    resetn = 1'b1;
    tick();

    // Job 1: K=3 C=2 base=6, with ignored restarts at +5 and +10.
    drive_a(1'b1, 2, 1, 6);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) if_a.start = 1'b0;
      if (k == 5 || k == 10) drive_a(1'b1, 0, 0, 1);
      if (k == 6 || k == 11) if_a.start = 1'b0;
      if (k == 1) begin
        chk("j1_addr0_c1", 32'(if_a.weight_memory_address[0]), 6);
        chk("j1_rst0_c1", 32'(if_a.reset_accumulators[0]), 1);
        chk("j1_busy_c1", 32'(if_a.busy), 1);
      end
      if (k == 2) begin
        chk("j1_addr0_c2", 32'(if_a.weight_memory_address[0]), 7);
        chk("j1_rst0_c2", 32'(if_a.reset_accumulators[0]), 0);
      end
      if (k == 3) begin
        chk("j1_addr0_c3", 32'(if_a.weight_memory_address[0]), 0);
        chk("j1_ksi0_c3", 32'(if_a.kernel_step_index[0]), 2);
      end
      if (k == 4) begin
        chk("j1_shift0_c4", 32'(if_a.shift_partial_result[0]), 1);
        chk("j1_rst3_c4", 32'(if_a.reset_accumulators[3]), 1);
        chk("j1_addr3_c4", 32'(if_a.weight_memory_address[3]), 6);
      end
      if (k == 6)
        chk("j1_scnt0_c6", 32'(if_a.shift_output_steps_counter[0]), 2);
      if (k == 9) begin
        chk("j1_fin_c9",
            32'(if_a.shift_output_steps_counter_finished_flag), 1);
        chk("j1_lcf_c9", 32'(if_a.last_column_finished), 0);
      end
      if (k == 15) begin
        chk("j1_lcf_c15", 32'(if_a.last_column_finished), 1);
        chk("j1_busy_c15", 32'(if_a.busy), 1);
      end
      if (k == 16) begin
        chk("j1_done_c16", 32'(if_a.done), 1);
        chk("j1_busy_c16", 32'(if_a.busy), 0);
      end
      if (k == 17) chk("j1_done_c17", 32'(if_a.done), 0);
    end

    // Job 2: aborted by reset in cycle 7, clean job from cycle 9.
    drive_a(1'b1, 2, 1, 6);
    for (int k = 1; k <= 28; k++) begin
      tick();
      if (k == 1) if_a.start = 1'b0;
      if (k == 7) resetn = 1'b0;
      if (k == 8) begin
        resetn = 1'b1;
        chk("j2_busy_c8", 32'(if_a.busy), 0);
        chk("j2_done_c8", 32'(if_a.done), 0);
        chk("j2_shift0_c8", 32'(if_a.shift_partial_result[0]), 0);
        chk("j2_ksi3_c8", 32'(if_a.kernel_step_index[3]), 0);
      end
      if (k == 9) drive_a(1'b1, 1, 2, 3);
      if (k == 10) begin
        if_a.start = 1'b0;
        chk("j2_addr0_c10", 32'(if_a.weight_memory_address[0]), 3);
      end
      if (k == 11) chk("j2_ksi0_c11", 32'(if_a.kernel_step_index[0]), 1);
      if (k == 25) chk("j2_done_c25", 32'(if_a.done), 1);
    end

    // Job 3: K=4 C=1 base=5, address wraps past the bank end.
    drive_a(1'b1, 3, 0, 5);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) if_a.start = 1'b0;
      if (k == 4) begin
        chk("j3_addr0_c4", 32'(if_a.weight_memory_address[0]), 0);
        chk("j3_ksi0_c4", 32'(if_a.kernel_step_index[0]), 3);
      end
      if (k == 12) chk("j3_done_c12", 32'(if_a.done), 1);
    end

    // Job 4: K=1 C=1 on both the N=4 and the N=1 instance.
    drive_a(1'b1, 0, 0, 7);
    if_b.start = 1'b1;
    if_b.cfg_kernel_steps_minus_one = '0;
    if_b.cfg_columns_minus_one = '0;
    if_b.cfg_weight_base_address = 3'd2;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        chk("b_ksi_c1", 32'(if_b.kernel_step_index[0]), 0);
        chk("b_rst_c1", 32'(if_b.reset_accumulators[0]), 1);
        chk("b_addr_c1", 32'(if_b.weight_memory_address[0]), 2);
        chk("b_shift_c1", 32'(if_b.shift_partial_result[0]), 0);
        chk("b_busy_c1", 32'(if_b.busy), 1);
      end
      if (k == 2) begin
        chk("b_shift_c2", 32'(if_b.shift_partial_result[0]), 1);
        chk("b_fin_c2",
            32'(if_b.shift_output_steps_counter_finished_flag), 1);
        chk("b_lcf_c2", 32'(if_b.last_column_finished), 1);
        chk("b_done_c2", 32'(if_b.done), 0);
      end
      if (k == 3) begin
        chk("b_done_c3", 32'(if_b.done), 1);
        chk("b_busy_c3", 32'(if_b.busy), 0);
        chk("b_dly_c3", 32'(if_b.delayed_shift_partial_result_flag), 1);
      end
      if (k == 4) chk("b_done_c4", 32'(if_b.done), 0);
      if (k == 6) chk("a_done_c6", 32'(if_a.done), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/computation_control_sequencer.md
Name: computation_control_sequencer

Overview:
- Master side of the computation-control bundle: per output column it sequences the kernel steps, the weight-memory addresses, the accumulator reset, and the partial-result shift-out for every PE array in a row.
- Sits between the layer scheduler (which issues start and config) and the PE-array row plus the weight line buffers.
- PE array i sees exactly the same control pattern as array 0, delayed by i cycles (systolic skew).

Parameters:
- NUMBER_OF_PE_ARRAYS_PER_ROW, 32, number of PE arrays driven (N).
- SUPPORTED_MAX_NUMBER_OF_KERNEL_STEPS, 4, maximum kernel steps per column.
- WEIGHT_BANK_DEPTH, 8, weight bank depth; address width is $clog2 of this.
- SUPPORTED_MAX_NUMBER_OF_COLUMNS, 256, maximum columns per job.
- KERNEL_STEPS_COUNTER_BIT_WIDTH (localparam), $clog2(SUPPORTED_MAX_NUMBER_OF_KERNEL_STEPS).

Ports:
- clk  in  1  single clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  job request; sampled only while busy=0.
- cfg_kernel_steps_minus_one  in  KSW  number of kernel steps K, minus one.
- cfg_columns_minus_one  in  $clog2(MAX_COLUMNS)  number of columns C, minus one.
- cfg_weight_base_address  in  $clog2(WEIGHT_BANK_DEPTH)  weight address used for step 0.
- kernel_step_index[N]  out  KSW  current kernel step, per array.
- weight_memory_address[N]  out  $clog2(DEPTH)  weight read address, per array.
- reset_accumulators[N]  out  1  clear accumulators on step 0, per array.
- shift_partial_result[N]  out  1  shift-out phase active, per array.
- shift_output_steps_counter[N]  out  KSW  shift step index, per array.
- shift_output_steps_counter_finished_flag  out  1  last shift step of array N-1.
- last_column_finished  out  1  array N-1 is completing the final shift of the last column.
- delayed_shift_partial_result_flag  out  1  shift_partial_result[0] delayed 1 cycle.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when the job has fully drained.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - All outputs go to 0, the FSM goes to IDLE, and the whole skew pipeline is cleared.
  - This applies mid-job too: the job is aborted, with no partial done pulse.
- Config latch: cfg_* are latched on the cycle start is accepted; later changes to cfg_* are ignored until the next job.
- FSM states: IDLE, COMPUTE, SHIFT, DRAIN.
  - IDLE -> COMPUTE on start=1.
  - COMPUTE: step counter runs 0..K-1, then -> SHIFT.
  - SHIFT: shift counter runs 0..K-1. At the end, if the column counter is below C-1, increment it and -> COMPUTE; otherwise -> DRAIN.
  - DRAIN: waits N-1 cycles, then -> IDLE and pulses done.
- Array-0 outputs (registered). Start is sampled at cycle 0; array 0 is active in cycles 1..2KC.
  - COMPUTE: kernel_step_index = step; weight_memory_address = (base + step) mod WEIGHT_BANK_DEPTH, wrapping naturally; reset_accumulators = 1 only when step = 0.
  - SHIFT: shift_partial_result = 1; shift_output_steps_counter = shift step.
  - All other fields are 0 when not in the corresponding phase.
- Skew: array i outputs equal array 0 outputs delayed by i cycles. The delay is a register chain; no per-array counters.
- Flags:
  - shift_output_steps_counter_finished_flag = shift_partial_result[N-1] AND shift_output_steps_counter[N-1] = K-1.
  - last_column_finished = that flag AND the delayed column index = C-1.
- Busy and done:
  - busy is high in cycles 1..2KC+N-1.
  - done pulses at cycle 2KC+N, in the same cycle busy falls.
  - start is accepted again from that cycle on.
- Start while busy: ignored; no queueing.
- Boundary cases:
  - K=1: COMPUTE and SHIFT each last 1 cycle.
  - C=1: a single column.
  - N=1: DRAIN lasts 0 cycles, so DRAIN -> IDLE immediately.

Decomposition:
- Package computation_control_pkg holds:
  - the FSM state enum;
  - a packed struct control_word_t {kernel_step_index, weight_memory_address, reset_accumulators, shift_partial_result, shift_output_steps_counter, column_is_last};
  - width localparams.
- Sub-module control_skew_pipeline: a chain of N control_word_t registers with synchronous active-low clear, fanning out one word per array.

Test Plan (N=4, K=3 (minus_one=2), C=2, base=6, DEPTH=8 unless stated):
- start at cycle 0:
  - array 0, cycles 1-3: step 0,1,2; addr 6,7,0; reset_accumulators only in cycle 1.
  - array 0, cycles 4-6: shift with counter 0,1,2.
  - array 3: the same pattern, starting at cycle 4.
- Flags for the same job:
  - finished_flag high in cycles 9 and 15.
  - last_column_finished high only in cycle 15.
  - done pulse in cycle 16; busy high in cycles 1-15.
- start re-asserted in cycles 5 and 10 with changed cfg -> ignored; the running pattern and the latched cfg are unchanged.
- resetn=0 in cycle 7 -> all outputs 0 in cycle 8 with no done pulse; a new start in cycle 9 gives a clean job.
- K=1, C=1, N=1 -> cycle 1 compute step 0 with reset_accumulators=1; cycle 2 shift with finished_flag=1 and last_column_finished=1; done in cycle 3.
- delayed_shift_partial_result_flag equals shift_partial_result[0] shifted by exactly 1 cycle over the full first job.
